// File: rtl/fb_vga_scanout_if.sv
// VGA connector bundle: sync, 4-bit colour channels and the frame-start marker.
`timescale 1ns/1ps

interface fb_vga_scanout_if;
   logic       vga_hs;
   logic       vga_vs;
   logic [3:0] vga_r;
   logic [3:0] vga_g;
   logic [3:0] vga_b;
   logic       frame_start;

   modport master (
      output vga_hs,
      output vga_vs,
      output vga_r,
      output vga_g,
      output vga_b,
      output frame_start
   );

   modport slave (
      input vga_hs,
      input vga_vs,
      input vga_r,
      input vga_g,
      input vga_b,
      input frame_start
   );
endinterface

// File: rtl/fb_vga_scanout.sv
// 640x480@60 VGA scanout of a 40x30 one-bit framebuffer, each logical pixel
// drawn as a 16x16 block. The framebuffer is copied once per frame at the
// start of vertical blanking so the visible image never tears.
`timescale 1ns/1ps

module fb_vga_scanout #(
   parameter int          CLKS_PER_PIXEL = 2,
   parameter logic [11:0] FG_COLOR       = 12'hFFF,
   parameter logic [11:0] BG_COLOR       = 12'h000
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [1199:0]          framebuffer,
   fb_vga_scanout_if.master       vga
);

   localparam logic [2:0] PRESC_MAX  = 3'(CLKS_PER_PIXEL - 1);
   localparam logic [9:0] H_VISIBLE  = 10'd640;
   localparam logic [9:0] H_SYNC_BEG = 10'd656;
   localparam logic [9:0] H_SYNC_END = 10'd751;
   localparam logic [9:0] H_LAST     = 10'd799;
   localparam logic [9:0] V_VISIBLE  = 10'd480;
   localparam logic [9:0] V_SYNC_BEG = 10'd490;
   localparam logic [9:0] V_SYNC_END = 10'd491;
   localparam logic [9:0] V_LAST     = 10'd524;

   // Linear framebuffer index of a logical pixel: row*40 + col as shifts.
   function automatic logic [10:0] pixel_index(input logic [4:0] row,
                                               input logic [5:0] col);
      return {1'b0, row, 5'b0} + {3'b0, row, 3'b0} + {5'b0, col};
   endfunction

   logic [2:0]    presc;
   logic          tick;
   logic [9:0]    h_count_p0;
   logic [9:0]    v_count_p0;
   logic [1199:0] snap;
   logic          snap_load;
   logic          h_wrap;
   logic          visible_p0;
   logic [10:0]   index_p0;
   logic [11:0]   colour_p0;
   logic          hs_p1;
   logic          vs_p1;
   logic [11:0]   colour_p1;
   logic          frame_start_p1;

   // With one clock per pixel the prescaler stays at 0 and tick is constant.
   assign tick      = (presc == PRESC_MAX);
   assign h_wrap    = (h_count_p0 == H_LAST);
   assign snap_load = tick && (h_count_p0 == 10'd0) && (v_count_p0 == V_VISIBLE);

   // Pixel-rate prescaler.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         presc <= 3'd0;
      end else if (tick) begin
         presc <= 3'd0;
      end else begin
         presc <= presc + 3'd1;
      end
   end

   // Stage 0: horizontal and vertical raster counters.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         h_count_p0 <= 10'd0;
         v_count_p0 <= 10'd0;
      end else if (tick) begin
         if (h_wrap) begin
            h_count_p0 <= 10'd0;
            if (v_count_p0 == V_LAST) begin
               v_count_p0 <= 10'd0;
            end else begin
               v_count_p0 <= v_count_p0 + 10'd1;
            end
         end else begin
            h_count_p0 <= h_count_p0 + 10'd1;
         end
      end
   end

   // Capture the framebuffer once per frame on entry to vertical blanking.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         snap <= '0;
      end else if (snap_load) begin
         snap <= framebuffer;
      end
   end

   // Colour lookup for the pixel the counters currently address.
   always_comb begin
      visible_p0 = (h_count_p0 < H_VISIBLE) && (v_count_p0 < V_VISIBLE);
      index_p0   = pixel_index(v_count_p0[8:4], h_count_p0[9:4]);
      colour_p0  = 12'h000;
      if (visible_p0) begin
         colour_p0 = snap[index_p0] ? FG_COLOR : BG_COLOR;
      end
   end

   // Stage 1: registered sync and colour, one tick behind the counters.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hs_p1     <= 1'b1;
         vs_p1     <= 1'b1;
         colour_p1 <= 12'h000;
      end else if (tick) begin
         hs_p1     <= !((h_count_p0 >= H_SYNC_BEG) && (h_count_p0 <= H_SYNC_END));
         vs_p1     <= !((v_count_p0 >= V_SYNC_BEG) && (v_count_p0 <= V_SYNC_END));
         colour_p1 <= colour_p0;
      end
   end

   // Frame-start marker: registered every clock so it lasts exactly one clock.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         frame_start_p1 <= 1'b0;
      end else begin
         frame_start_p1 <= snap_load;
      end
   end

   assign vga.vga_hs      = hs_p1;
   assign vga.vga_vs      = vs_p1;
   assign vga.vga_r       = colour_p1[11:8];
   assign vga.vga_g       = colour_p1[7:4];
   assign vga.vga_b       = colour_p1[3:0];
   assign vga.frame_start = frame_start_p1;

endmodule
